pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Cycle-level sequencer for pipeline hold, flush and bubble actions in the 5-stage core.
- Consumes the hazard unit's load-use stall, the EX-stage taken-branch redirect and the data-memory busy signal.
- Drives all PC and pipeline-register enables and flushes from one prioritised FSM.
- Keeps saturating performance counters for stall, freeze and flush cycles.

Parameters:
- IMEM_LAT, 1: extra front-end bubble cycles after a branch redirect (FLUSH state length); 0 means FLUSH is never entered. Legal range 0..15.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- hdu_stall  in  1  load-use stall request from the hazard detection unit.
- ex_branch_taken  in  1  branch/jump in EX is taken; PC target is valid this cycle.
- dmem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- clr_cnt  in  1  synchronous clear of all performance counters.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- ex_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers.
- state  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 FLUSH.
- stall_cnt  out  CNT_W  load-use stall cycles.
- freeze_cnt  out  CNT_W  memory freeze cycles.
- flush_cnt  out  CNT_W  branch bubble cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset, sampled at the clk edge with rst_n=0:
  - Next state is RUN; flush_left=0; all counters =0.
  - While rst_n=0, outputs are pc_en=0, ifid_en=0, ex_en=0, ifid_flush=1, idex_flush=1.
- Output timing: outputs are combinational from the registered state plus inputs (Mealy), so stall and flush act in the same cycle as the request. State and counters update on the clock edge.
- Priority in RUN and on MEM_WAIT release: dmem_busy > ex_branch_taken > hdu_stall.
- RUN, no request: pc_en=ifid_en=ex_en=1, both flushes 0.
- RUN with dmem_busy=1:
  - All enables 0, flushes 0.
  - Next state MEM_WAIT; freeze_cnt++.
  - Any branch or hdu_stall in the same cycle is not acted on. Its source registers are frozen, so it is re-presented later.
- RUN with ex_branch_taken=1 (redirect cycle):
  - pc_en=1, ifid_en=1, ex_en=1, ifid_flush=1, idex_flush=1. hdu_stall is ignored.
  - flush_cnt++.
  - If IMEM_LAT>0: flush_left<=IMEM_LAT, next state FLUSH. Otherwise stay in RUN.
- RUN with hdu_stall=1:
  - pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, ex_en=1.
  - stall_cnt++. Stay in RUN; multi-cycle stalls repeat this each cycle.
- FLUSH with dmem_busy=0:
  - pc_en=ifid_en=ex_en=1, ifid_flush=1, idex_flush=0. ex_branch_taken and hdu_stall are ignored.
  - flush_cnt++; flush_left--.
  - Next state RUN when flush_left==1, else remain in FLUSH.
- FLUSH with dmem_busy=1: all enables 0, flushes 0, flush_left holds, freeze_cnt++, next state MEM_WAIT.
- MEM_WAIT with dmem_busy=1: all enables 0, flushes 0, freeze_cnt++.
- MEM_WAIT with dmem_busy=0 (release cycle):
  - If flush_left!=0, behave as FLUSH (outputs, decrement, counter) and go to FLUSH, or to RUN if flush_left==1.
  - Otherwise behave exactly as RUN, including a branch/stall decode in that same cycle.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_cnt zeroes all counters; it takes precedence over increments in the same cycle.
  - Counters are not affected by state.
- Reset mid-FLUSH or mid-MEM_WAIT returns to RUN with flush_left=0 on that edge. No residual flush.
- Encoding 11 is unreachable; if entered, next state is RUN with RUN outputs.

Test Plan:
- Reset (IMEM_LAT=1): hold rst_n=0 for 2 cycles with all inputs 1 -> pc_en=0, ifid_flush=1, idex_flush=1. After release: state=00, all counters 0, pc_en=ifid_en=ex_en=1.
- Load-use: hdu_stall=1 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1, ex_en=1; stall_cnt 0->1. Next cycle all enables 1.
- Branch, IMEM_LAT=2: ex_branch_taken pulse -> cycle0 ifid_flush=1, idex_flush=1, state->10. Cycles 1-2 ifid_flush=1, idex_flush=0. Cycle 3 state=00; flush_cnt=3.
- Freeze with simultaneous requests: dmem_busy=1 for 3 cycles while ex_branch_taken=hdu_stall=1 -> enables 0 for 3 cycles, freeze_cnt=3. Release cycle: branch redirect (ifid_flush=idex_flush=1), stall_cnt stays 0.
- Busy inside FLUSH, IMEM_LAT=3: dmem_busy for 2 cycles after the first FLUSH cycle -> state 01 for 2 cycles, then exactly 2 more FLUSH-behaviour cycles (release cycle counts as one); flush_cnt=4 total.
- Saturation and clear, CNT_W=4: hdu_stall held 20 cycles -> stall_cnt=15. Then clr_cnt=1 together with hdu_stall=1 -> stall_cnt=0 next cycle. Then rst_n=0 mid-FLUSH -> state=00, no further ifid_flush after reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush/bubble sequencer for the 5-stage core.
// A single prioritised FSM drives the PC and pipeline-register enables and keeps saturating event counters.
module pipe_hazard_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hdu_stall,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    localparam logic [3:0] LAT = 4'(IMEM_LAT);

    state_t     cur_state, next_state;
    logic [3:0] flush_left, next_flush_left;
    logic       act_run, act_flush, act_freeze;
    logic       inc_stall, inc_freeze, inc_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state  <= ST_RUN;
            flush_left <= 4'd0;
        end else begin
            cur_state  <= next_state;
            flush_left <= next_flush_left;
        end
    end

    // Decide which kind of cycle this is, then apply a single action block for it.
    always_comb begin
        act_run    = 1'b0;
        act_flush  = 1'b0;
        act_freeze = 1'b0;
        case (cur_state)
            ST_RUN:      act_run = 1'b1;
            ST_FLUSH: begin
                if (dmem_busy) act_freeze = 1'b1;
                else           act_flush  = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (dmem_busy)               act_freeze = 1'b1;
                else if (flush_left != 4'd0) act_flush  = 1'b1;
                else                         act_run    = 1'b1;
            end
            default: ;
        endcase
        if (act_run && dmem_busy) begin
            act_run    = 1'b0;
            act_freeze = 1'b1;
        end
    end

    always_comb begin
        pc_en           = 1'b1;
        ifid_en         = 1'b1;
        ex_en           = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        next_state      = ST_RUN;
        next_flush_left = flush_left;
        inc_stall       = 1'b0;
        inc_freeze      = 1'b0;
        inc_flush       = 1'b0;

        if (act_freeze) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ex_en      = 1'b0;
            next_state = ST_MEM_WAIT;
            inc_freeze = 1'b1;
        end else if (act_flush) begin
            ifid_flush      = 1'b1;
            inc_flush       = 1'b1;
            next_flush_left = flush_left - 4'd1;
            next_state      = (flush_left == 4'd1) ? ST_RUN : ST_FLUSH;
        end else if (act_run && ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            inc_flush  = 1'b1;
            if (LAT != 4'd0) begin
                next_flush_left = LAT;
                next_state      = ST_FLUSH;
            end
        end else if (act_run && hdu_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            inc_stall  = 1'b1;
        end

        // Reset holds the front end and injects bubbles regardless of state.
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ex_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (inc_stall && stall_cnt != '1)   stall_cnt  <= stall_cnt + 1'b1;
            if (inc_freeze && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 1'b1;
            if (inc_flush && flush_cnt != '1)   flush_cnt  <= flush_cnt + 1'b1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: four instances with different IMEM_LAT/CNT_W share one stimulus,
// and each step checks the outputs of the instance under test.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hdu_stall, ex_branch_taken, dmem_busy, clr_cnt;

    logic [3:0]  pc_en_v, ifid_en_v, ifid_flush_v, idex_flush_v, ex_en_v;
    logic [1:0]  st_v  [4];
    logic [15:0] sc_v  [4];
    logic [15:0] fc_v  [4];
    logic [15:0] flc_v [4];
    logic [3:0]  sc_c, fc_c, flc_c;

    assign sc_v[2]  = {12'd0, sc_c};
    assign fc_v[2]  = {12'd0, fc_c};
    assign flc_v[2] = {12'd0, flc_c};

    pipe_hazard_ctrl #(.IMEM_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .hdu_stall(hdu_stall), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .clr_cnt(clr_cnt), .pc_en(pc_en_v[0]), .ifid_en(ifid_en_v[0]),
        .ifid_flush(ifid_flush_v[0]), .idex_flush(idex_flush_v[0]), .ex_en(ex_en_v[0]),
        .state(st_v[0]), .stall_cnt(sc_v[0]), .freeze_cnt(fc_v[0]), .flush_cnt(flc_v[0]));

    pipe_hazard_ctrl #(.IMEM_LAT(2), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .hdu_stall(hdu_stall), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .clr_cnt(clr_cnt), .pc_en(pc_en_v[1]), .ifid_en(ifid_en_v[1]),
        .ifid_flush(ifid_flush_v[1]), .idex_flush(idex_flush_v[1]), .ex_en(ex_en_v[1]),
        .state(st_v[1]), .stall_cnt(sc_v[1]), .freeze_cnt(fc_v[1]), .flush_cnt(flc_v[1]));

    pipe_hazard_ctrl #(.IMEM_LAT(3), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .hdu_stall(hdu_stall), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .clr_cnt(clr_cnt), .pc_en(pc_en_v[2]), .ifid_en(ifid_en_v[2]),
        .ifid_flush(ifid_flush_v[2]), .idex_flush(idex_flush_v[2]), .ex_en(ex_en_v[2]),
        .state(st_v[2]), .stall_cnt(sc_c), .freeze_cnt(fc_c), .flush_cnt(flc_c));

    pipe_hazard_ctrl #(.IMEM_LAT(0), .CNT_W(16)) u_d (
        .clk(clk), .rst_n(rst_n), .hdu_stall(hdu_stall), .ex_branch_taken(ex_branch_taken),
        .dmem_busy(dmem_busy), .clr_cnt(clr_cnt), .pc_en(pc_en_v[3]), .ifid_en(ifid_en_v[3]),
        .ifid_flush(ifid_flush_v[3]), .idex_flush(idex_flush_v[3]), .ex_en(ex_en_v[3]),
        .state(st_v[3]), .stall_cnt(sc_v[3]), .freeze_cnt(fc_v[3]), .flush_cnt(flc_v[3]));

    // eo packs {pc_en, ifid_en, ex_en, ifid_flush, idex_flush}; registered fields are pre-edge values.
    typedef struct {
        logic        rst_n, stall, br, busy, clr;
        logic [4:0]  eo;
        logic        chk;
        logic [1:0]  es;
        logic [15:0] esc, efc, eflc;
    } vec_t;

    localparam logic [4:0] O_RUN = 5'b11100, O_STALL = 5'b00101, O_BR = 5'b11111,
                           O_FL  = 5'b11110, O_FRZ   = 5'b00000, O_RST = 5'b00011;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic applyStimulus(input logic r, input logic s, input logic b, input logic m, input logic c);
        rst_n = r; hdu_stall = s; ex_branch_taken = b; dmem_busy = m; clr_cnt = c;
    endtask

    task automatic checkOutput(input string name, input int inst, input logic [4:0] eo, input logic chk,
                               input logic [1:0] es, input logic [15:0] esc, input logic [15:0] efc,
                               input logic [15:0] eflc);
        logic [4:0] ao;
        logic bad;
        ao  = {pc_en_v[inst], ifid_en_v[inst], ex_en_v[inst], ifid_flush_v[inst], idex_flush_v[inst]};
        bad = (ao !== eo);
        if (chk)
            bad = bad || (st_v[inst] !== es) || (sc_v[inst] !== esc) ||
                  (fc_v[inst] !== efc) || (flc_v[inst] !== eflc);
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("[TB] FAIL %s: got out=%b st=%b cnt=%0d/%0d/%0d, want out=%b st=%b cnt=%0d/%0d/%0d",
                     name, ao, st_v[inst], sc_v[inst], fc_v[inst], flc_v[inst], eo, es, esc, efc, eflc);
        end
    endtask

    task automatic step(input string name, input int inst, input logic r, input logic s, input logic b,
                        input logic m, input logic c, input logic [4:0] eo, input logic chk,
                        input logic [1:0] es, input logic [15:0] esc, input logic [15:0] efc,
                        input logic [15:0] eflc);
        applyStimulus(r, s, b, m, c);
        #1;
        checkOutput(name, inst, eo, chk, es, esc, efc, eflc);
        @(negedge clk);
    endtask

    vec_t tbl[17];

    initial begin
        //            rst  stl  br   busy clr   outputs  chk  st     stall freeze flush
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, O_RST,   1'b0,2'b00,16'd0,16'd0,16'd0};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, O_RST,   1'b1,2'b00,16'd0,16'd0,16'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, O_RUN,   1'b1,2'b00,16'd0,16'd0,16'd0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, O_STALL, 1'b1,2'b00,16'd0,16'd0,16'd0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, O_RUN,   1'b1,2'b00,16'd1,16'd0,16'd0};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, O_BR,    1'b1,2'b00,16'd1,16'd0,16'd0};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, O_FL,    1'b1,2'b10,16'd1,16'd0,16'd1};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, O_RUN,   1'b1,2'b00,16'd1,16'd0,16'd2};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, O_FRZ,   1'b1,2'b00,16'd1,16'd0,16'd2};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, O_FRZ,   1'b1,2'b01,16'd1,16'd1,16'd2};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0, O_BR,    1'b1,2'b01,16'd1,16'd2,16'd2};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0, O_FRZ,   1'b1,2'b10,16'd1,16'd2,16'd3};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, O_FL,    1'b1,2'b01,16'd1,16'd3,16'd3};
        tbl[13] = '{1'b1,1'b1,1'b0,1'b0,1'b1, O_STALL, 1'b1,2'b00,16'd1,16'd3,16'd4};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0, O_RUN,   1'b1,2'b00,16'd0,16'd0,16'd0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0, O_RST,   1'b1,2'b00,16'd0,16'd0,16'd0};
        tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, O_RUN,   1'b1,2'b00,16'd0,16'd0,16'd0};

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 17; i++)
            step($sformatf("lat1_vec%0d", i), 0, tbl[i].rst_n, tbl[i].stall, tbl[i].br, tbl[i].busy,
                 tbl[i].clr, tbl[i].eo, tbl[i].chk, tbl[i].es, tbl[i].esc, tbl[i].efc, tbl[i].eflc);

        // Two-cycle front-end bubble after a redirect.
        step("lat2_rst", 1, 0,0,0,0,0, O_RST, 1'b0, 2'b00, 0, 0, 0);
        step("lat2_rst2", 1, 0,0,0,0,0, O_RST, 1'b1, 2'b00, 0, 0, 0);
        step("lat2_br", 1, 1,0,1,0,0, O_BR, 1'b1, 2'b00, 0, 0, 0);
        step("lat2_fl1", 1, 1,0,0,0,0, O_FL, 1'b1, 2'b10, 0, 0, 1);
        step("lat2_fl2", 1, 1,0,0,0,0, O_FL, 1'b1, 2'b10, 0, 0, 2);
        step("lat2_done", 1, 1,0,0,0,0, O_RUN, 1'b1, 2'b00, 0, 0, 3);

        // Memory freeze in the middle of a three-cycle bubble, then saturation and clear.
        step("lat3_rst", 2, 0,0,0,0,0, O_RST, 1'b0, 2'b00, 0, 0, 0);
        step("lat3_rst2", 2, 0,0,0,0,0, O_RST, 1'b1, 2'b00, 0, 0, 0);
        step("lat3_br", 2, 1,0,1,0,0, O_BR, 1'b1, 2'b00, 0, 0, 0);
        step("lat3_fl1", 2, 1,0,0,0,0, O_FL, 1'b1, 2'b10, 0, 0, 1);
        step("lat3_busy1", 2, 1,0,0,1,0, O_FRZ, 1'b1, 2'b10, 0, 0, 2);
        step("lat3_busy2", 2, 1,0,0,1,0, O_FRZ, 1'b1, 2'b01, 0, 1, 2);
        step("lat3_release", 2, 1,0,0,0,0, O_FL, 1'b1, 2'b01, 0, 2, 2);
        step("lat3_fl3", 2, 1,0,0,0,0, O_FL, 1'b1, 2'b10, 0, 2, 3);
        step("lat3_done", 2, 1,0,0,0,0, O_RUN, 1'b1, 2'b00, 0, 2, 4);
        for (int i = 0; i < 20; i++)
            step($sformatf("sat_stall%0d", i), 2, 1,1,0,0,0, O_STALL, 1'b1, 2'b00,
                 16'((i < 15) ? i : 15), 2, 4);
        step("sat_clr", 2, 1,1,0,0,1, O_STALL, 1'b1, 2'b00, 15, 2, 4);
        step("sat_after_clr", 2, 1,0,0,0,0, O_RUN, 1'b1, 2'b00, 0, 0, 0);
        step("mid_br", 2, 1,0,1,0,0, O_BR, 1'b1, 2'b00, 0, 0, 0);
        step("mid_fl", 2, 1,0,0,0,0, O_FL, 1'b1, 2'b10, 0, 0, 1);
        step("mid_rst", 2, 0,0,0,0,0, O_RST, 1'b1, 2'b10, 0, 0, 2);
        step("mid_after1", 2, 1,0,0,0,0, O_RUN, 1'b1, 2'b00, 0, 0, 0);
        step("mid_after2", 2, 1,0,0,0,0, O_RUN, 1'b1, 2'b00, 0, 0, 0);

        // Zero latency: a redirect never enters FLUSH.
        step("lat0_rst", 3, 0,0,0,0,0, O_RST, 1'b0, 2'b00, 0, 0, 0);
        step("lat0_rst2", 3, 0,0,0,0,0, O_RST, 1'b1, 2'b00, 0, 0, 0);
        step("lat0_br1", 3, 1,0,1,0,0, O_BR, 1'b1, 2'b00, 0, 0, 0);
        step("lat0_br2", 3, 1,1,1,0,0, O_BR, 1'b1, 2'b00, 0, 0, 1);
        step("lat0_done", 3, 1,0,0,0,0, O_RUN, 1'b1, 2'b00, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
